// File: rtl/pipe_ctrl_nlane_pkg.sv
// Shared definitions for the N-lane pipeline controller: FSM encodings, stall/flush patterns, saturating helper.
// Patterns are 32 bits wide and get truncated or zero-extended to NSTAGE at the point of use.
package pipe_ctrl_nlane_pkg;

    typedef enum logic [1:0] {
        CTRL_RUN    = 2'd0,
        CTRL_FDRAIN = 2'd1,
        CTRL_WFI    = 2'd2
    } ctrl_state_e;

    localparam logic [31:0] STALL_IF  = 32'h0000_0001;
    localparam logic [31:0] STALL_ID  = 32'h0000_0003;
    localparam logic [31:0] STALL_EX  = 32'h0000_0007;
    localparam logic [31:0] STALL_ALL = 32'hFFFF_FFFF;

    localparam logic [31:0] FLUSH_IFID   = 32'h0000_0001;
    localparam logic [31:0] FLUSH_IDEX   = 32'h0000_0002;
    localparam logic [31:0] FLUSH_EXMEM  = 32'h0000_0004;
    localparam logic [31:0] FLUSH_BRANCH = 32'h0000_0003;

    function automatic logic [31:0] satInc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_ctrl_nlane_lane_prio_sel.sv
// Lowest-index priority select across issue lanes: winner one-hot, younger-lane kill mask and target mux.
module lane_prio_sel
    import pipe_ctrl_nlane_pkg::*;
#(
    parameter int ISSUE_W    = 2,
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ISSUE_W-1:0]            i_req,
    input  logic [ISSUE_W*ADDR_WIDTH-1:0] i_pc,
    output logic [ISSUE_W-1:0]            o_onehot,
    output logic [ISSUE_W-1:0]            o_kill,
    output logic [ADDR_WIDTH-1:0]         o_pc
);

    logic w_seen;

    // Every lane above the first requester is younger and gets killed, requesting or not.
    always_comb begin
        o_onehot = '0;
        o_kill   = '0;
        o_pc     = '0;
        w_seen   = 1'b0;
        for (int i = 0; i < ISSUE_W; i++) begin
            if (w_seen) begin
                o_kill[i] = 1'b1;
            end else if (i_req[i]) begin
                o_onehot[i] = 1'b1;
                o_pc        = i_pc[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_seen      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl_nlane.sv
// N-lane pipeline controller: branch resolution, per-stage stall/flush, FENCE_DRAIN and WFI_SLEEP FSM.
// Optional perf counters are enabled by defining CTRL_PERF_CNT_EN.
module pipe_ctrl_nlane
    import pipe_ctrl_nlane_pkg::*;
#(
    parameter int ISSUE_W    = 2,
    parameter int NSTAGE     = 5,
    parameter int ADDR_WIDTH = 32,
    parameter int FENCE_TMO  = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          icache_stall_req,
    input  logic                          dcache_stall_req,
    input  logic                          hazard_stall_req,
    input  logic                          ex_stall_req,
    input  logic [ISSUE_W-1:0]            id_fence,
    input  logic [ISSUE_W-1:0]            id_wfi,
    input  logic [ISSUE_W-1:0]            ex_ldst,
    input  logic [ISSUE_W-1:0]            mem_ldst,
    input  logic [ISSUE_W-1:0]            ex_branch,
    input  logic [ISSUE_W*ADDR_WIDTH-1:0] ex_branch_pc,
    input  logic                          csr_excp,
    input  logic                          csr_wfi_clr,
    output logic [NSTAGE-1:0]             ctrl_stall,
    output logic [NSTAGE-2:0]             flush,
    output logic [ISSUE_W-1:0]            lane_kill,
    output logic                          branch_flag,
    output logic [ADDR_WIDTH-1:0]         branch_pc,
    output logic                          fence_mem_req,
    output logic                          fence_tmo,
    output logic [1:0]                    ctrl_state
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]                   perf_stall_cnt,
    output logic [31:0]                   perf_flush_cnt
`endif
);

    localparam int CW = $clog2(FENCE_TMO);
    localparam logic [CW-1:0] CNT_LAST = CW'(FENCE_TMO - 1);

    ctrl_state_e         r_state;
    ctrl_state_e         w_next;
    logic [CW-1:0]       r_cnt;
    logic [ISSUE_W-1:0]  w_onehot;
    logic [ISSUE_W-1:0]  w_kill;
    logic                w_branch;
    logic                w_ldst_any;
    logic                w_fence_entry;
    logic                w_wfi_entry;
    logic                w_drain_exit;
    logic [NSTAGE-2:0]   w_br_flush;

    lane_prio_sel #(
        .ISSUE_W    (ISSUE_W),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_prio (
        .i_req    (ex_branch),
        .i_pc     (ex_branch_pc),
        .o_onehot (w_onehot),
        .o_kill   (w_kill),
        .o_pc     (branch_pc)
    );

    assign w_branch    = |w_onehot;
    assign branch_flag = w_branch;
    assign w_ldst_any  = |(ex_ldst | mem_ldst);
    assign w_br_flush  = w_branch ? (NSTAGE-1)'(FLUSH_BRANCH) : '0;

    // A fence beats a simultaneous wfi; the wfi is still sitting in ID after the drain and re-requests then.
    assign w_fence_entry = (r_state == CTRL_RUN) && (|id_fence) && w_ldst_any && !w_branch && !csr_excp;
    assign w_wfi_entry   = (r_state == CTRL_RUN) && (|id_wfi) && !csr_wfi_clr && !w_branch && !csr_excp
                           && !w_fence_entry;
    assign w_drain_exit  = (r_state == CTRL_FDRAIN) && (!w_ldst_any || (r_cnt == CNT_LAST));
    assign fence_tmo     = (r_state == CTRL_FDRAIN) && (r_cnt == CNT_LAST) && w_ldst_any;
    assign ctrl_state    = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CTRL_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (csr_excp) begin
            w_next = CTRL_RUN;
        end else begin
            case (r_state)
                CTRL_RUN: begin
                    if (w_fence_entry)    w_next = CTRL_FDRAIN;
                    else if (w_wfi_entry) w_next = CTRL_WFI;
                end
                CTRL_FDRAIN: if (w_drain_exit) w_next = CTRL_RUN;
                CTRL_WFI:    if (csr_wfi_clr)  w_next = CTRL_RUN;
                default:     w_next = CTRL_RUN;
            endcase
        end
    end

    // Drain cycle counter: zero on the first drain cycle, cleared on every way out of the drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if ((r_state == CTRL_FDRAIN) && !csr_excp && !w_drain_exit) begin
            r_cnt <= r_cnt + CW'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // An accepted wfi request outranks all stall sources; an exception overrides everything.
    always_comb begin
        ctrl_stall    = '0;
        flush         = '0;
        lane_kill     = w_kill;
        fence_mem_req = 1'b0;
        case (r_state)
            CTRL_WFI: ctrl_stall = NSTAGE'(STALL_ALL);
            CTRL_FDRAIN: begin
                fence_mem_req = 1'b1;
                flush         = w_br_flush;
                ctrl_stall    = dcache_stall_req ? NSTAGE'(STALL_EX) : NSTAGE'(STALL_ID);
            end
            default: begin
                flush = w_br_flush;
                if (!w_wfi_entry) begin
                    if (hazard_stall_req) begin
                        ctrl_stall = NSTAGE'(STALL_ID);
                        flush      = flush | (NSTAGE-1)'(FLUSH_IDEX);
                    end else if (dcache_stall_req) begin
                        ctrl_stall = NSTAGE'(STALL_EX);
                        flush      = flush | (NSTAGE-1)'(FLUSH_EXMEM);
                    end else if (icache_stall_req) begin
                        ctrl_stall = NSTAGE'(STALL_IF);
                        flush      = flush | (NSTAGE-1)'(FLUSH_IFID);
                    end else if (ex_stall_req) begin
                        ctrl_stall = NSTAGE'(STALL_EX);
                        flush      = flush | (NSTAGE-1)'(FLUSH_EXMEM);
                    end
                end
            end
        endcase
        if (csr_excp) begin
            ctrl_stall = '0;
            flush      = '1;
            lane_kill  = '1;
        end
    end

`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (|ctrl_stall)           perf_stall_cnt <= satInc(perf_stall_cnt);
            if (w_branch || csr_excp)  perf_flush_cnt <= satInc(perf_flush_cnt);
        end
    end
`else
    // Without the perf option no counter state exists; all other behaviour is unchanged.
`endif

endmodule

// File: tb/tb_pipe_ctrl_nlane.sv
// Self-checking bench for pipe_ctrl_nlane: directed vector table, corner sequences, randomized run vs model.
// Perf counters are checked when CTRL_PERF_CNT_EN is defined.
module tb_pipe_ctrl_nlane;

    localparam int IW  = 2;
    localparam int NS  = 5;
    localparam int AW  = 32;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic icache_stall_req, dcache_stall_req, hazard_stall_req, ex_stall_req;
    logic [IW-1:0] id_fence, id_wfi, ex_ldst, mem_ldst, ex_branch;
    logic [IW*AW-1:0] ex_branch_pc;
    logic csr_excp, csr_wfi_clr;
    logic [NS-1:0] ctrl_stall;
    logic [NS-2:0] flush;
    logic [IW-1:0] lane_kill;
    logic branch_flag;
    logic [AW-1:0] branch_pc;
    logic fence_mem_req, fence_tmo;
    logic [1:0] ctrl_state;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    pipe_ctrl_nlane #(.ISSUE_W(IW), .NSTAGE(NS), .ADDR_WIDTH(AW), .FENCE_TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .icache_stall_req(icache_stall_req), .dcache_stall_req(dcache_stall_req),
        .hazard_stall_req(hazard_stall_req), .ex_stall_req(ex_stall_req),
        .id_fence(id_fence), .id_wfi(id_wfi), .ex_ldst(ex_ldst), .mem_ldst(mem_ldst),
        .ex_branch(ex_branch), .ex_branch_pc(ex_branch_pc),
        .csr_excp(csr_excp), .csr_wfi_clr(csr_wfi_clr),
        .ctrl_stall(ctrl_stall), .flush(flush), .lane_kill(lane_kill),
        .branch_flag(branch_flag), .branch_pc(branch_pc),
        .fence_mem_req(fence_mem_req), .fence_tmo(fence_tmo), .ctrl_state(ctrl_state)
`ifdef CTRL_PERF_CNT_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] br;
        logic [AW-1:0] pc0, pc1;
        logic hz, dc, ic, ex;
        logic [IW-1:0] fen, wfi, exl, meml;
        logic excp, wclr;
    } stim_t;

    typedef struct {
        stim_t s;
        logic [NS-1:0] stall;
        logic [NS-2:0] fl;
        logic [IW-1:0] kill;
        logic flag;
        logic [AW-1:0] pc;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // Reference model state: 0 RUN, 1 FENCE_DRAIN, 2 WFI_SLEEP; drain cycle number starting at 0.
    int m_state, m_cnt, m_nstate, m_ncnt;
    longint m_ps, m_pf;
    logic [NS-1:0] e_stall;
    logic [NS-2:0] e_flush;
    logic [IW-1:0] e_kill;
    logic e_flag, e_memreq, e_tmo;
    logic [AW-1:0] e_pc;
    int drainCnt, sleepCnt, tmoCnt, tmoAt;

    vec_t vecs[18];

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idleStim();
        stim_t s;
        s.br = '0; s.pc0 = '0; s.pc1 = '0;
        s.hz = 0; s.dc = 0; s.ic = 0; s.ex = 0;
        s.fen = '0; s.wfi = '0; s.exl = '0; s.meml = '0;
        s.excp = 0; s.wclr = 0;
        return s;
    endfunction

    function automatic vec_t mkVec(input logic [IW-1:0] br, input logic hz, dc, ic, ex,
                                   input logic [IW-1:0] fen, wfi, exl, meml, input logic excp, wclr,
                                   input logic [NS-1:0] stall, input logic [NS-2:0] fl,
                                   input logic [IW-1:0] kill, input logic flag, input logic [AW-1:0] pc);
        vec_t v;
        v.s = idleStim();
        v.s.br = br; v.s.pc0 = 32'h100; v.s.pc1 = 32'h200;
        v.s.hz = hz; v.s.dc = dc; v.s.ic = ic; v.s.ex = ex;
        v.s.fen = fen; v.s.wfi = wfi; v.s.exl = exl; v.s.meml = meml;
        v.s.excp = excp; v.s.wclr = wclr;
        v.stall = stall; v.fl = fl; v.kill = kill; v.flag = flag; v.pc = pc;
        return v;
    endfunction

    task automatic driveInputs(input stim_t s);
        ex_branch = s.br;
        ex_branch_pc = {s.pc1, s.pc0};
        hazard_stall_req = s.hz; dcache_stall_req = s.dc;
        icache_stall_req = s.ic; ex_stall_req = s.ex;
        id_fence = s.fen; id_wfi = s.wfi; ex_ldst = s.exl; mem_ldst = s.meml;
        csr_excp = s.excp; csr_wfi_clr = s.wclr;
    endtask

    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        driveInputs(s);
    endtask

    task automatic modelEval();
        int win;
        logic ldstAny, fenceIn, wfiIn;
        win = -1;
        for (int i = 0; i < IW; i++) if (ex_branch[i] && win < 0) win = i;
        e_flag = (win >= 0);
        e_pc = '0;
        e_kill = '0;
        if (win >= 0) begin
            e_pc = ex_branch_pc[win*AW +: AW];
            for (int i = win + 1; i < IW; i++) e_kill[i] = 1'b1;
        end
        ldstAny = |(ex_ldst | mem_ldst);
        e_memreq = (m_state == 1);
        e_tmo = (m_state == 1) && (m_cnt == TMO - 1) && ldstAny;
        fenceIn = (m_state == 0) && (|id_fence) && ldstAny && win < 0 && !csr_excp;
        wfiIn = (m_state == 0) && (|id_wfi) && !csr_wfi_clr && win < 0 && !csr_excp && !fenceIn;
        e_stall = '0;
        e_flush = '0;
        if (csr_excp) begin
            e_flush = '1;
            e_kill = '1;
        end else if (m_state == 2) begin
            e_stall = '1;
        end else begin
            if (win >= 0) e_flush = 4'b0011;
            if (m_state == 1) e_stall = dcache_stall_req ? 5'b00111 : 5'b00011;
            else if (!wfiIn) begin
                if (hazard_stall_req)      begin e_stall = 5'b00011; e_flush |= 4'b0010; end
                else if (dcache_stall_req) begin e_stall = 5'b00111; e_flush |= 4'b0100; end
                else if (icache_stall_req) begin e_stall = 5'b00001; e_flush |= 4'b0001; end
                else if (ex_stall_req)     begin e_stall = 5'b00111; e_flush |= 4'b0100; end
            end
        end
        m_nstate = m_state;
        m_ncnt = 0;
        if (csr_excp) m_nstate = 0;
        else if (m_state == 0) begin
            if (fenceIn) m_nstate = 1;
            else if (wfiIn) m_nstate = 2;
        end else if (m_state == 1) begin
            if (!ldstAny || m_cnt == TMO - 1) m_nstate = 0;
            else m_ncnt = m_cnt + 1;
        end else if (csr_wfi_clr) m_nstate = 0;
    endtask

    task automatic checkOutput(input string tag);
        #1;
        modelEval();
        cmp({tag, ".state"}, ctrl_state, 64'(m_state));
        cmp({tag, ".stall"}, ctrl_stall, e_stall);
        cmp({tag, ".flush"}, flush, e_flush);
        cmp({tag, ".kill"}, lane_kill, e_kill);
        cmp({tag, ".bflag"}, branch_flag, e_flag);
        cmp({tag, ".bpc"}, branch_pc, e_pc);
        cmp({tag, ".memreq"}, fence_mem_req, e_memreq);
        cmp({tag, ".tmo"}, fence_tmo, e_tmo);
`ifdef CTRL_PERF_CNT_EN
        cmp({tag, ".pstall"}, perf_stall_cnt, 64'(m_ps));
        cmp({tag, ".pflush"}, perf_flush_cnt, 64'(m_pf));
`endif
    endtask

    task automatic runCycle(input string tag);
        checkOutput(tag);
        if (ctrl_state == 2'd1) drainCnt++;
        if (ctrl_state == 2'd2) sleepCnt++;
        if (fence_tmo === 1'b1) begin tmoCnt++; tmoAt = drainCnt; end
        @(posedge clk);
        if (|e_stall && m_ps < 64'hFFFF_FFFF) m_ps++;
        if ((e_flag || csr_excp) && m_pf < 64'hFFFF_FFFF) m_pf++;
        m_state = m_nstate;
        m_cnt = m_ncnt;
    endtask

    task automatic doReset(input string tag);
        @(negedge clk);
        driveInputs(idleStim());
        rst = 1'b1;
        #2;
        cmp({tag, ".rst_state"}, ctrl_state, 0);
        cmp({tag, ".rst_stall"}, ctrl_stall, 0);
        cmp({tag, ".rst_memreq"}, fence_mem_req, 0);
        cmp({tag, ".rst_tmo"}, fence_tmo, 0);
`ifdef CTRL_PERF_CNT_EN
        cmp({tag, ".rst_pstall"}, perf_stall_cnt, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        m_state = 0; m_cnt = 0; m_ps = 0; m_pf = 0;
        drainCnt = 0; sleepCnt = 0; tmoCnt = 0; tmoAt = 0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        stim_t s;
        // br hz dc ic ex fen wfi exl meml excp wclr | stall flush kill flag pc
        vecs[0]  = mkVec(2'b00,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0, 5'b00000,4'b0000,2'b00,0,32'h0);
        vecs[1]  = mkVec(2'b11,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0, 5'b00000,4'b0011,2'b10,1,32'h100);
        vecs[2]  = mkVec(2'b10,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0, 5'b00000,4'b0011,2'b00,1,32'h200);
        vecs[3]  = mkVec(2'b01,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0, 5'b00000,4'b0011,2'b10,1,32'h100);
        vecs[4]  = mkVec(2'b00,1,1,0,0,2'b00,2'b00,2'b00,2'b00,0,0, 5'b00011,4'b0010,2'b00,0,32'h0);
        vecs[5]  = mkVec(2'b00,0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,0, 5'b00111,4'b0100,2'b00,0,32'h0);
        vecs[6]  = mkVec(2'b00,0,0,1,0,2'b00,2'b00,2'b00,2'b00,0,0, 5'b00001,4'b0001,2'b00,0,32'h0);
        vecs[7]  = mkVec(2'b00,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0,0, 5'b00111,4'b0100,2'b00,0,32'h0);
        vecs[8]  = mkVec(2'b00,0,0,1,1,2'b00,2'b00,2'b00,2'b00,0,0, 5'b00001,4'b0001,2'b00,0,32'h0);
        vecs[9]  = mkVec(2'b01,1,0,0,0,2'b00,2'b00,2'b00,2'b00,1,0, 5'b00000,4'b1111,2'b11,1,32'h100);
        vecs[10] = mkVec(2'b11,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0, 5'b00011,4'b0011,2'b10,1,32'h100);
        vecs[11] = mkVec(2'b01,0,0,1,0,2'b00,2'b00,2'b00,2'b00,0,0, 5'b00001,4'b0011,2'b10,1,32'h100);
        vecs[12] = mkVec(2'b00,0,0,0,0,2'b01,2'b00,2'b00,2'b00,0,0, 5'b00000,4'b0000,2'b00,0,32'h0);
        vecs[13] = mkVec(2'b00,0,0,1,0,2'b00,2'b01,2'b00,2'b00,0,1, 5'b00001,4'b0001,2'b00,0,32'h0);
        vecs[14] = mkVec(2'b01,1,0,0,0,2'b00,2'b10,2'b00,2'b00,0,0, 5'b00011,4'b0011,2'b10,1,32'h100);
        vecs[15] = mkVec(2'b10,0,0,0,0,2'b01,2'b00,2'b00,2'b01,0,0, 5'b00000,4'b0011,2'b00,1,32'h200);
        vecs[16] = mkVec(2'b00,0,1,0,0,2'b00,2'b00,2'b11,2'b00,0,0, 5'b00111,4'b0100,2'b00,0,32'h0);
        vecs[17] = mkVec(2'b00,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0, 5'b00000,4'b0000,2'b00,0,32'h0);

        driveInputs(idleStim());
        m_state = 0; m_cnt = 0; m_ps = 0; m_pf = 0;
        #3;
        cmp("init.state", ctrl_state, 0);
        cmp("init.stall", ctrl_stall, 0);
        doReset("t0");

        // Directed table: none of these may leave RUN
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].s);
            #1;
            cmp($sformatf("vec%0d.state", i), ctrl_state, 0);
            cmp($sformatf("vec%0d.stall", i), ctrl_stall, vecs[i].stall);
            cmp($sformatf("vec%0d.flush", i), flush, vecs[i].fl);
            cmp($sformatf("vec%0d.kill", i), lane_kill, vecs[i].kill);
            cmp($sformatf("vec%0d.bflag", i), branch_flag, vecs[i].flag);
            cmp($sformatf("vec%0d.bpc", i), branch_pc, vecs[i].pc);
            @(posedge clk);
        end

        // Fence drain with natural exit
        doReset("fence");
        s = idleStim(); s.fen = 2'b01; s.meml = 2'b01;
        applyStimulus(s); runCycle("fence.entry");
        s.fen = 2'b00;
        for (int k = 0; k < 3; k++) begin applyStimulus(s); runCycle("fence.drain"); end
        s.meml = 2'b00;
        applyStimulus(s); runCycle("fence.last");
        applyStimulus(s); runCycle("fence.after");
        cmp("fence.drain_cycles", 64'(drainCnt), 4);
        cmp("fence.tmo_count", 64'(tmoCnt), 0);

        // Fence drain timeout with load/store held
        doReset("tmo");
        s = idleStim(); s.fen = 2'b01; s.exl = 2'b10;
        applyStimulus(s); runCycle("tmo.entry");
        s.fen = 2'b00;
        for (int k = 0; k < 6; k++) begin applyStimulus(s); runCycle("tmo.drain"); end
        cmp("tmo.drain_cycles", 64'(drainCnt), 4);
        cmp("tmo.count", 64'(tmoCnt), 1);
        cmp("tmo.at_cycle", 64'(tmoAt), 4);

        // WFI sleep and wake
        doReset("wfi");
        s = idleStim(); s.wfi = 2'b10;
        applyStimulus(s); runCycle("wfi.req");
        s = idleStim();
        for (int k = 0; k < 3; k++) begin applyStimulus(s); runCycle("wfi.sleep"); end
        s.wclr = 1'b1;
        applyStimulus(s); runCycle("wfi.wake");
        s = idleStim();
        applyStimulus(s); runCycle("wfi.run");
        cmp("wfi.sleep_cycles", 64'(sleepCnt), 4);
        cmp("wfi.final_stall", ctrl_stall, 0);

        // Exception during drain together with a branch
        doReset("excp");
        s = idleStim(); s.fen = 2'b11; s.meml = 2'b01;
        applyStimulus(s); runCycle("excp.entry");
        s.fen = 2'b00;
        applyStimulus(s); runCycle("excp.drain");
        s.excp = 1'b1; s.br = 2'b01; s.pc0 = 32'hABC0; s.pc1 = 32'h1230;
        applyStimulus(s);
        #1;
        cmp("excp.flush", flush, 4'hF);
        cmp("excp.kill", lane_kill, 2'b11);
        cmp("excp.stall", ctrl_stall, 0);
        runCycle("excp.hit");
        s = idleStim(); s.meml = 2'b01;
        applyStimulus(s); runCycle("excp.after");
        cmp("excp.drain_cycles", 64'(drainCnt), 2);

        // Fence and wfi together: fence first, wfi accepted after the drain
        doReset("fw");
        s = idleStim(); s.fen = 2'b01; s.wfi = 2'b10; s.meml = 2'b01;
        applyStimulus(s); runCycle("fw.entry");
        s.fen = 2'b00;
        applyStimulus(s); runCycle("fw.drain");
        s.meml = 2'b00;
        applyStimulus(s); runCycle("fw.exit");
        applyStimulus(s); runCycle("fw.wfireq");
        s = idleStim();
        applyStimulus(s); runCycle("fw.sleep");
        cmp("fw.drain_cycles", 64'(drainCnt), 2);
        cmp("fw.sleep_cycles", 64'(sleepCnt), 1);

        // Reset in the middle of sleep and of a drain
        doReset("rs");
        s = idleStim(); s.wfi = 2'b01;
        applyStimulus(s); runCycle("rs.req");
        doReset("rs.sleep");
        s = idleStim(); s.fen = 2'b01; s.exl = 2'b01;
        applyStimulus(s); runCycle("rs.fence");
        doReset("rs.drain");

        // Randomized run against the model
        for (int k = 0; k < 1500; k++) begin
            s = idleStim();
            s.br = ($urandom_range(0, 5) == 0) ? IW'($urandom) : '0;
            s.pc0 = $urandom; s.pc1 = $urandom;
            s.hz = ($urandom_range(0, 5) == 0);
            s.dc = ($urandom_range(0, 5) == 0);
            s.ic = ($urandom_range(0, 5) == 0);
            s.ex = ($urandom_range(0, 5) == 0);
            s.fen = ($urandom_range(0, 4) == 0) ? IW'($urandom) : '0;
            s.wfi = ($urandom_range(0, 7) == 0) ? IW'($urandom) : '0;
            s.exl = ($urandom_range(0, 2) == 0) ? IW'($urandom) : '0;
            s.meml = ($urandom_range(0, 2) == 0) ? IW'($urandom) : '0;
            s.excp = ($urandom_range(0, 29) == 0);
            s.wclr = ($urandom_range(0, 4) == 0);
            applyStimulus(s);
            runCycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
